riscv_core_mul_ctrl: RTL

- Iterative multiply sequencer for the EX-stage M-extension unit.
- Accepts one MUL/MULH/MULHSU/MULHU/MULW operation through a valid/ready handshake and converts signed operands to magnitudes.
- Runs a radix-2 shift-add loop over one shared XLEN-bit adder, applies sign correction, selects the result half, and pulses done.
- Sits between the decode/issue interface and the writeback mux. Supports pipeline flush.

---
 rtl/riscv_core_mul_ctrl_if.sv | 42 ++++
 rtl/riscv_core_mul_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/riscv_core_mul_ctrl_if.sv
// Issue/writeback bundle of the iterative multiplier: request, operands, flush and result.
// Handshake: an operation transfers on a rising edge where valid && ready && !flush; ready is high only while idle.
interface riscv_core_mul_ctrl_if #(
    parameter int XLEN = 64
) ();
    logic            i_mul_ctrl_valid;
    logic            o_mul_ctrl_ready;
    logic [XLEN-1:0] i_mul_ctrl_srcA;
    logic [XLEN-1:0] i_mul_ctrl_srcB;
    logic [1:0]      i_mul_ctrl_control;
    logic            i_mul_ctrl_isword;
    logic            i_mul_ctrl_flush;
    logic            o_mul_ctrl_busy;
    logic            o_mul_ctrl_done;
    logic [XLEN-1:0] o_mul_ctrl_result;

    modport master (
        output i_mul_ctrl_valid,
        output i_mul_ctrl_srcA,
        output i_mul_ctrl_srcB,
        output i_mul_ctrl_control,
        output i_mul_ctrl_isword,
        output i_mul_ctrl_flush,
        input  o_mul_ctrl_ready,
        input  o_mul_ctrl_busy,
        input  o_mul_ctrl_done,
        input  o_mul_ctrl_result
    );

    modport slave (
        input  i_mul_ctrl_valid,
        input  i_mul_ctrl_srcA,
        input  i_mul_ctrl_srcB,
        input  i_mul_ctrl_control,
        input  i_mul_ctrl_isword,
        input  i_mul_ctrl_flush,
        output o_mul_ctrl_ready,
        output o_mul_ctrl_busy,
        output o_mul_ctrl_done,
        output o_mul_ctrl_result
    );
endinterface

// File: rtl/riscv_core_mul_ctrl.sv
// Radix-2 shift-add multiply sequencer for MUL/MULH/MULHSU/MULHU/MULW with sign fix-up,
// result half select and flush. o_dbg_state exposes the FSM state for checkers.
module riscv_core_mul_ctrl #(
    parameter int XLEN = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    riscv_core_mul_ctrl_if.slave mul_if,
    output logic [1:0]           o_dbg_state
);
    localparam int W  = XLEN / 2;
    localparam int CW = $clog2(XLEN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CW-1:0] C_ITER_DWORD = CW'(XLEN);
    localparam logic [CW-1:0] C_ITER_WORD  = CW'(W);

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0]   r_mcand;
    logic              r_neg;
    logic [1:0]        r_ctrl;
    logic              r_isword;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [XLEN:0]     w_addend;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_prod_step;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_result_sel;

    // Word operands are negated within the low half and zero-extended, so the
    // most-negative value still yields its exact unsigned magnitude.
    function automatic logic [XLEN-1:0] f_mag(input logic [XLEN-1:0] x,
                                              input logic            neg,
                                              input logic            word);
        logic [W-1:0] lo;
        lo = x[W-1:0];
        if (word) begin
            if (neg) lo = ~lo + 1'b1;
            f_mag = {{W{1'b0}}, lo};
        end else begin
            f_mag = neg ? (~x + 1'b1) : x;
        end
    endfunction

    assign w_accept   = (r_state == S_IDLE) && mul_if.i_mul_ctrl_valid && !mul_if.i_mul_ctrl_flush;
    assign w_a_signed = mul_if.i_mul_ctrl_isword || (mul_if.i_mul_ctrl_control != 2'b11);
    assign w_b_signed = mul_if.i_mul_ctrl_isword || !mul_if.i_mul_ctrl_control[1];

    always_comb begin
        w_a_neg = 1'b0;
        w_b_neg = 1'b0;
        if (mul_if.i_mul_ctrl_isword) begin
            w_a_neg = mul_if.i_mul_ctrl_srcA[W-1];
            w_b_neg = mul_if.i_mul_ctrl_srcB[W-1];
        end else begin
            w_a_neg = w_a_signed && mul_if.i_mul_ctrl_srcA[XLEN-1];
            w_b_neg = w_b_signed && mul_if.i_mul_ctrl_srcB[XLEN-1];
        end
    end

    assign w_mag_a = f_mag(mul_if.i_mul_ctrl_srcA, w_a_neg, mul_if.i_mul_ctrl_isword);
    assign w_mag_b = f_mag(mul_if.i_mul_ctrl_srcB, w_b_neg, mul_if.i_mul_ctrl_isword);

    // One shared adder: conditional add of the multiplicand into the high half,
    // then the carry, high and low halves shift right together.
    assign w_addend    = r_prod[0] ? {1'b0, r_mcand} : '0;
    assign w_sum       = {1'b0, r_prod[2*XLEN-1:XLEN]} + w_addend;
    assign w_prod_step = {w_sum, r_prod[XLEN-1:1]};

    assign w_prod_fix = r_neg ? (~r_prod + 1'b1) : r_prod;

    // A word product ends up in the window [XLEN+W-1:W]; its low half is [XLEN-1:W].
    always_comb begin
        w_result_sel = w_prod_fix[XLEN-1:0];
        if (r_isword) begin
            w_result_sel = {{W{w_prod_fix[XLEN-1]}}, w_prod_fix[XLEN-1:W]};
        end else if (r_ctrl != 2'b00) begin
            w_result_sel = w_prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_neg    <= 1'b0;
            r_ctrl   <= 2'b00;
            r_isword <= 1'b0;
            r_result <= '0;
        end else if (mul_if.i_mul_ctrl_flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state  <= S_BUSY;
                        r_cnt    <= mul_if.i_mul_ctrl_isword ? C_ITER_WORD : C_ITER_DWORD;
                        r_prod   <= {{XLEN{1'b0}}, w_mag_b};
                        r_mcand  <= w_mag_a;
                        r_neg    <= w_a_neg ^ w_b_neg;
                        r_ctrl   <= mul_if.i_mul_ctrl_control;
                        r_isword <= mul_if.i_mul_ctrl_isword;
                    end
                end
                S_BUSY: begin
                    // The counter hits zero after the last iteration; that cycle only hands over to FIX.
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_prod <= w_prod_step;
                        r_cnt  <= r_cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    r_prod   <= w_prod_fix;
                    r_result <= w_result_sel;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mul_if.o_mul_ctrl_ready  = (r_state == S_IDLE);
    assign mul_if.o_mul_ctrl_busy   = (r_state != S_IDLE);
    assign mul_if.o_mul_ctrl_done   = (r_state == S_DONE);
    assign mul_if.o_mul_ctrl_result = r_result;
    assign o_dbg_state              = r_state;

endmodule
